// File: rtl/fp_pkg.sv
// Shared binary32 field constants, operand classes and the issue-entry payload
// for the fp_add_issue stage.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_t;

  typedef struct packed {
    logic [31:0] num1;
    logic [31:0] num2;
    logic        special;
    logic [31:0] special_result;
  } issue_entry_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational binary32 operand classifier; denormals are reported as ZERO
// so the issue stage flushes them.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] num,
  output fp_class_t   cls
);

  logic [EXP_W-1:0] exp_s;
  logic [MAN_W-1:0] man_s;

  assign exp_s = num[MAN_W +: EXP_W];
  assign man_s = num[MAN_W-1:0];

  // Class decode from exponent and mantissa fields
  always_comb begin
    cls = NORM;
    if (exp_s == {EXP_W{1'b0}}) begin
      cls = ZERO;
    end else if (exp_s == EXP_MAX) begin
      if (man_s != {MAN_W{1'b0}}) begin
        cls = NAN;
      end else begin
        cls = INF;
      end
    end else begin
      cls = NORM;
    end
  end

endmodule

// File: rtl/fp_add_issue.sv
// Issue stage ahead of fp_adder: 2-entry skid buffer whose entries carry
// flushed operands and a pre-resolved IEEE special-case bypass result.
module fp_add_issue
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_num1,
  input  logic [31:0] in_num2,
  input  logic        in_add_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_num1,
  output logic [31:0] out_num2,
  output logic        out_add_sub,
  output logic        out_special,
  output logic [31:0] out_special_result
);

  fp_class_t    cls_a_s;
  fp_class_t    cls_b_s;
  logic         sb_s;
  logic         sa_s;
  issue_entry_t new_entry_s;

  issue_entry_t main_r, skid_r, main_n_s, skid_n_s;
  logic         main_valid_r, skid_valid_r, main_valid_n_s, skid_valid_n_s;
  logic         in_ready_r;
  logic         accept_s, drain_s;

  fp_classify u_cls_a (.num(in_num1), .cls(cls_a_s));
  fp_classify u_cls_b (.num(in_num2), .cls(cls_b_s));

  assign sa_s     = in_num1[31];
  assign sb_s     = in_num2[31] ^ in_add_sub;
  assign accept_s = in_valid & in_ready_r;
  assign drain_s  = main_valid_r & out_ready;

  // Build the entry: flush denormals, apply effective B sign, resolve specials
  always_comb begin
    new_entry_s      = '0;
    new_entry_s.num1 = (cls_a_s == ZERO) ? {sa_s, 31'b0} : in_num1;
    new_entry_s.num2 = (cls_b_s == ZERO) ? {sb_s, 31'b0} : {sb_s, in_num2[30:0]};
    new_entry_s.special = 1'b1;
    if ((cls_a_s == NAN) || (cls_b_s == NAN)) begin
      new_entry_s.special_result = QNAN;
    end else if ((cls_a_s == INF) && (cls_b_s == INF) && (sa_s != sb_s)) begin
      new_entry_s.special_result = QNAN;
    end else if (cls_a_s == INF) begin
      new_entry_s.special_result = in_num1;
    end else if (cls_b_s == INF) begin
      new_entry_s.special_result = {sb_s, in_num2[30:0]};
    end else if ((cls_a_s == ZERO) && (cls_b_s == ZERO)) begin
      new_entry_s.special_result = {sa_s & sb_s, 31'b0};
    end else if (cls_a_s == ZERO) begin
      new_entry_s.special_result = {sb_s, in_num2[30:0]};
    end else if (cls_b_s == ZERO) begin
      new_entry_s.special_result = in_num1;
    end else if ((in_num1[30:0] == in_num2[30:0]) && (sa_s != sb_s)) begin
      new_entry_s.special_result = 32'h0000_0000;
    end else begin
      new_entry_s.special        = 1'b0;
      new_entry_s.special_result = 32'h0000_0000;
    end
  end

  // Skid-buffer next state: drain first, then place the accepted entry
  always_comb begin
    main_n_s       = main_r;
    main_valid_n_s = main_valid_r;
    skid_n_s       = skid_r;
    skid_valid_n_s = skid_valid_r;
    if (drain_s) begin
      if (skid_valid_r) begin
        main_n_s       = skid_r;
        main_valid_n_s = 1'b1;
        skid_n_s       = '0;
        skid_valid_n_s = 1'b0;
      end else begin
        main_n_s       = '0;
        main_valid_n_s = 1'b0;
      end
    end else begin
      main_n_s = main_r;
    end
    // in_ready guarantees skid is empty whenever an accept happens
    if (accept_s) begin
      if (!main_valid_n_s) begin
        main_n_s       = new_entry_s;
        main_valid_n_s = 1'b1;
      end else begin
        skid_n_s       = new_entry_s;
        skid_valid_n_s = 1'b1;
      end
    end else begin
      skid_n_s = skid_n_s;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      main_r       <= main_n_s;
      skid_r       <= skid_n_s;
      main_valid_r <= main_valid_n_s;
      skid_valid_r <= skid_valid_n_s;
      in_ready_r   <= ~skid_valid_n_s;
    end
  end

  assign in_ready           = in_ready_r;
  assign out_valid          = main_valid_r;
  assign out_num1           = main_r.num1;
  assign out_num2           = main_r.num2;
  assign out_add_sub        = 1'b0;
  assign out_special        = main_r.special;
  assign out_special_result = main_r.special_result;

endmodule

// File: tb/tb_fp_add_issue.sv
// Self-checking bench for fp_add_issue: directed cases plus randomized traffic
// checked against a queue-based reference model of the issue stage.
module tb_fp_add_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_num1 = 32'h0;
  logic [31:0] in_num2 = 32'h0;
  logic        in_add_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_num1, out_num2, out_special_result;
  logic        out_add_sub, out_special;

  int checks = 0;
  int errors = 0;

  logic [96:0] exp_q[$];
  logic        model_rdy = 1'b0;

  fp_add_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_num1(in_num1), .in_num2(in_num2), .in_add_sub(in_add_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_num1(out_num1),
    .out_num2(out_num2), .out_add_sub(out_add_sub), .out_special(out_special),
    .out_special_result(out_special_result)
  );

  always #5 clk = ~clk;

  // Reference: {num1, num2, special, special_result} from the operand rules
  function automatic logic [96:0] ref_entry(input logic [31:0] a, input logic [31:0] b, input logic as);
    logic sb;
    logic a_zero, a_nan, a_inf, b_zero, b_nan, b_inf;
    logic [31:0] n1, n2, res;
    logic sp;
    sb     = b[31] ^ as;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    n1 = a_zero ? {a[31], 31'h0} : a;
    n2 = b_zero ? {sb, 31'h0} : {sb, b[30:0]};
    sp = 1'b1;
    if (a_nan || b_nan)                       res = 32'h7FC00000;
    else if (a_inf && b_inf && a[31] != sb)   res = 32'h7FC00000;
    else if (a_inf)                           res = a;
    else if (b_inf)                           res = {sb, b[30:0]};
    else if (a_zero && b_zero)                res = {a[31] & sb, 31'h0};
    else if (a_zero)                          res = {sb, b[30:0]};
    else if (b_zero)                          res = a;
    else if (a[30:0] == b[30:0] && a[31] != sb) res = 32'h00000000;
    else begin sp = 1'b0; res = 32'h00000000; end
    return {n1, n2, sp, res};
  endfunction

  // Drive one cycle, advance the model, then check the DUT against it
  task automatic step(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic as, input logic ordy);
    logic acc, pop;
    rst = r; in_valid = v; in_num1 = a; in_num2 = b; in_add_sub = as; out_ready = ordy;
    acc = !r && v && model_rdy;
    pop = !r && ordy && (exp_q.size() != 0);
    @(negedge clk);
    if (r) begin
      exp_q.delete();
      model_rdy = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_entry(a, b, as));
      model_rdy = (exp_q.size() < 2);
    end
    checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL out_valid: got %b want %b", out_valid, exp_q.size() != 0);
    end
    checks++;
    if (in_ready !== model_rdy) begin
      errors++; $display("FAIL in_ready: got %b want %b", in_ready, model_rdy);
    end
    checks++;
    if (out_add_sub !== 1'b0) begin
      errors++; $display("FAIL out_add_sub: got %b want 0", out_add_sub);
    end
    if (exp_q.size() != 0) begin
      checks++;
      if ({out_num1, out_num2, out_special, out_special_result} !== exp_q[0]) begin
        errors++;
        $display("FAIL payload: got %h %h %b %h want %h %h %b %h",
                 out_num1, out_num2, out_special, out_special_result,
                 exp_q[0][96:65], exp_q[0][64:33], exp_q[0][32], exp_q[0][31:0]);
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 32'h40000000, 32'h40000000, 1'b0, 1'b0);
    checks++;
    if ({out_valid, in_ready, out_special, out_special_result, out_num1, out_num2} !== 99'h0) begin
      errors++; $display("FAIL reset_state: got v=%b r=%b sp=%b res=%h n1=%h n2=%h want all 0",
                         out_valid, in_ready, out_special, out_special_result, out_num1, out_num2);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_special_cases();
    step(1'b0, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_special, out_num2} !== {1'b1, 1'b0, 32'h40000000}) begin
      errors++; $display("FAIL plain_add: got v=%b sp=%b n2=%h want 1 0 40000000", out_valid, out_special, out_num2);
    end
    step(1'b0, 1'b1, 32'h40400000, 32'h40400000, 1'b1, 1'b1);
    checks++;
    if ({out_special, out_special_result} !== {1'b1, 32'h00000000}) begin
      errors++; $display("FAIL cancel: got %b %h want 1 00000000", out_special, out_special_result);
    end
    step(1'b0, 1'b1, 32'h7F800000, 32'h7F800000, 1'b1, 1'b1);
    checks++;
    if ({out_special, out_special_result} !== {1'b1, 32'h7FC00000}) begin
      errors++; $display("FAIL inf_minus_inf: got %b %h want 1 7fc00000", out_special, out_special_result);
    end
    step(1'b0, 1'b1, 32'h7F800001, 32'h3F800000, 1'b0, 1'b1);
    checks++;
    if ({out_special, out_special_result} !== {1'b1, 32'h7FC00000}) begin
      errors++; $display("FAIL nan_in: got %b %h want 1 7fc00000", out_special, out_special_result);
    end
    step(1'b0, 1'b1, 32'h00000001, 32'hBF800000, 1'b0, 1'b1);
    checks++;
    if ({out_num1, out_special, out_special_result} !== {32'h00000000, 1'b1, 32'hBF800000}) begin
      errors++; $display("FAIL denorm_flush: got %h %b %h want 00000000 1 bf800000", out_num1, out_special, out_special_result);
    end
    step(1'b0, 1'b1, 32'h80000000, 32'h00000000, 1'b1, 1'b1);
    checks++;
    if ({out_special, out_special_result} !== {1'b1, 32'h80000000}) begin
      errors++; $display("FAIL neg_zero: got %b %h want 1 80000000", out_special, out_special_result);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back_stall();
    step(1'b0, 1'b1, 32'h41000000, 32'h3F800000, 1'b0, 1'b0);  // P0
    step(1'b0, 1'b1, 32'h41100000, 32'h3F800000, 1'b0, 1'b0);  // P1
    checks++;
    if ({in_ready, out_num1} !== {1'b0, 32'h41000000}) begin
      errors++; $display("FAIL stall_full: got ready=%b n1=%h want 0 41000000", in_ready, out_num1);
    end
    step(1'b0, 1'b1, 32'h41200000, 32'h3F800000, 1'b0, 1'b0);  // P2 offered, refused
    checks++;
    if (out_num1 !== 32'h41000000) begin
      errors++; $display("FAIL stall_hold: got %h want 41000000", out_num1);
    end
    step(1'b0, 1'b1, 32'h41200000, 32'h3F800000, 1'b0, 1'b1);
    checks++;
    if (out_num1 !== 32'h41100000) begin
      errors++; $display("FAIL order_p1: got %h want 41100000", out_num1);
    end
    step(1'b0, 1'b1, 32'h41200000, 32'h3F800000, 1'b0, 1'b1);
    checks++;
    if (out_num1 !== 32'h41200000) begin
      errors++; $display("FAIL order_p2: got %h want 41200000", out_num1);
    end
    step(1'b0, 1'b1, 32'h41300000, 32'h3F800000, 1'b0, 1'b1);  // P3
    checks++;
    if (out_num1 !== 32'h41300000) begin
      errors++; $display("FAIL order_p3: got %h want 41300000", out_num1);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_stall();
    step(1'b0, 1'b1, 32'h42000000, 32'h3F800000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h42100000, 32'h3F800000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h42200000, 32'h3F800000, 1'b0, 1'b1);
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++; $display("FAIL mid_stall_reset: got v=%b r=%b want 0 0", out_valid, in_ready);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL post_reset: got v=%b r=%b want 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: rand_op = {1'($urandom), 8'h00, 23'($urandom)};
      1: rand_op = {1'($urandom), 8'hFF, 23'h0};
      2: rand_op = {1'($urandom), 8'hFF, 23'($urandom_range(1, 8388607))};
      default: rand_op = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 400; i++) begin
      a = rand_op();
      b = ($urandom_range(0, 3) == 0) ? a : rand_op();
      step(1'b0, 1'($urandom_range(0, 3) != 0), a, b, 1'($urandom),
           1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    test_reset();
    test_special_cases();
    test_back_to_back_stall();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_issue.md
# fp_add_issue

Registered issue stage directly upstream of `fp_adder`. It accepts operand pairs over a valid/ready handshake, buffers them in a 2-entry skid buffer, and pre-applies the subtract sign flip. It flushes denormals to zero and resolves every IEEE-754 special case (NaN, infinity, zero, exact cancellation) into a bypass result. The downstream mux forwards `fp_adder.result` when `out_special=0` and `out_special_result` otherwise.

## Interface
- No parameters. Formats are fixed to binary32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: stage can accept. Registered.
- `in_num1` in 32: operand A.
- `in_num2` in 32: operand B.
- `in_add_sub` in 1: 0 = A+B, 1 = A−B.
- `out_valid` out 1: issued entry valid.
- `out_ready` in 1: downstream accepts.
- `out_num1` out 32: A, with denormal flushed to signed zero.
- `out_num2` out 32: B, with effective sign, denormal flushed.
- `out_add_sub` out 1: always 0, because the sign flip is already applied. Kept so `fp_adder` connects directly.
- `out_special` out 1: 1 = use `out_special_result`, ignore the adder.
- `out_special_result` out 32: bypass result; 0 when `out_special=0`.

## Operation
- Effective B sign: `sB = in_num2[31] ^ in_add_sub`.
- Classification per operand, by exp E and mantissa M:
  - ZERO: E=0, any M (flush-to-zero).
  - NAN: E=FF and M≠0.
  - INF: E=FF and M=0.
  - NORM otherwise.
- Flush: a ZERO-class operand is issued as `{sign, 31'b0}`.
- Special resolution, first match wins:
  1. Either NAN → 0x7FC00000.
  2. Both INF with A sign ≠ sB → 0x7FC00000.
  3. A INF → A.
  4. B INF → `{sB, B[30:0]}`.
  5. Both ZERO → `{A[31] & sB, 31'b0}`.
  6. A ZERO → `{sB, B[30:0]}`.
  7. B ZERO → A.
  8. `A[30:0]==B[30:0]` and A sign ≠ sB → 0x00000000 (exact cancellation, +0).
  9. Otherwise `out_special=0`.
- Classification and resolution are computed at input accept and stored with the entry. Nothing is computed combinationally on the output side.
- Skid buffer, main + skid register:
  - Accept when `in_valid & in_ready`.
  - Entry goes to main if main is empty or being drained that cycle, else to skid.
  - When main drains and skid is full, skid moves to main.
  - `in_ready` is the registered value of `!skid_full`.
- Output payload is held stable while `out_valid & !out_ready`.
- Entries are issued in order. None are dropped or duplicated.

## Timing
- Latency: accept at edge N → `out_valid=1` in the cycle after edge N, with no bubble when the stage is empty.
- Throughput: 1 pair/cycle when `out_ready` is held high.
- Stall: with `out_ready=0`, the second accepted pair fills skid and `in_ready` drops the next cycle. No third pair is accepted.
- Simultaneous accept and drain with skid full: skid→main and new entry→skid is illegal, because `in_ready=0`. With skid empty, the new entry→main in the same edge.
- Reset, any cycle including mid-stall:
  - Both entries cleared.
  - `out_valid=0`, `out_special=0`, `out_special_result=0`, `out_num1=0`, `out_num2=0`, `out_add_sub=0`.
  - `in_ready=0` while `rst` is high; `in_ready=1` in the first cycle after `rst` falls.
  - Inputs presented during reset are ignored.

## Structure
- `fp_pkg`:
  - Field widths: EXP_W=8, MAN_W=23.
  - `EXP_MAX=8'hFF`.
  - `QNAN=32'h7FC00000`.
  - Class enum `fp_class_t` {ZERO, NORM, INF, NAN}.
  - Entry struct: num1, num2, special, special_result.
- Sub-module `fp_classify`, combinational, instantiated twice: 32-bit in → `fp_class_t`.
- Skid buffer and resolution priority live in `fp_add_issue`.

## Test plan
- A=0x3F800000, B=0x40000000, add_sub=0 → one cycle later: `out_valid=1`, `out_special=0`, `out_num2=0x40000000`.
- A=0x40400000, B=0x40400000, add_sub=1 → `out_special=1`, `out_special_result=0x00000000`.
- A=0x7F800000, B=0x7F800000, add_sub=1 → result 0x7FC00000. A=0x7F800001, B=0x3F800000 → result 0x7FC00000.
- A=0x00000001 (denormal), B=0xBF800000, add_sub=0 → `out_num1=0x00000000`, `out_special=1`, result 0xBF800000. A=0x80000000, B=0x00000000, add_sub=1 → result 0x80000000.
- Back-to-back pairs P0..P3 with `out_ready=0` for 3 cycles → `in_ready` low after P1. P0 held stable on the outputs. On release, order is P0, P1, then P2 (accepted once ready returns); P3 is not lost.
- `rst` asserted mid-stall with 2 entries held → next cycle: `out_valid=0`, `in_ready=0`. After `rst` falls, `in_ready=1` and the flushed entries never appear.
